// File: rtl/dffn_pipe_bank.sv
// Purpose : WIDTH x STAGES falling-edge register pipeline with per-stage valid tag,
//           synchronous reset/clear/set, load enable and a full-bank scan chain.
// Latency : D/DV -> Q/QV after STAGES enabled falling edges; SI -> SO after WIDTH*STAGES scan edges.
// Backpr. : none; EN low stalls the whole pipe in place (not elastic), bubbles tracked only via DV.
//
// Ports:
//   CLKN      clock, every state update happens on its falling edge
//   RST       synchronous active-high reset (highest priority)
//   SE, SI    scan enable / scan serial in (second priority, valids hold)
//   CLR       synchronous clear of data and valids
//   SET       synchronous set of data to SET_VAL (valids hold)
//   EN        advance the pipe: D/DV into stage 0, every stage moves up by one
//   D, DV     stage 0 data and its valid tag
//   Q, QV     last-stage data and valid (direct register outputs)
//   SO        scan serial out, the MSB of the last stage

module dffn_pipe_bank #(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             CLKN,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             SET,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             SO
);

    localparam int NBITS = WIDTH * STAGES;

    // Whole-bank images of the constant loads.
    localparam logic [STAGES-1:0][WIDTH-1:0] RST_BANK = {STAGES{RESET_VAL}};
    localparam logic [STAGES-1:0][WIDTH-1:0] SET_BANK = {STAGES{SET_VAL}};

    // s[k][i] occupies flat bit k*WIDTH+i, so the packed bank read as one
    // vector is exactly the scan chain with SI entering at bit 0 and SO at
    // the top bit.
    logic [STAGES-1:0][WIDTH-1:0] s;
    logic [STAGES-1:0][WIDTH-1:0] s_shift;
    logic [STAGES-1:0][WIDTH-1:0] s_adv;
    logic [STAGES-1:0][WIDTH-1:0] s_nxt;
    logic [STAGES-1:0]            v;
    logic [STAGES-1:0]            v_adv;
    logic [STAGES-1:0]            v_nxt;
    logic [NBITS-1:0]             chain;

    assign chain = s;

    generate
        if (NBITS == 1) begin : g_shift_one
            assign s_shift = SI;
        end else begin : g_shift_many
            assign s_shift = {chain[NBITS-2:0], SI};
        end

        if (STAGES == 1) begin : g_adv_one
            assign s_adv = D;
            assign v_adv = DV;
        end else begin : g_adv_many
            assign s_adv = {s[STAGES-2:0], D};
            assign v_adv = {v[STAGES-2:0], DV};
        end
    endgenerate

    // Priority RST > SE > CLR > SET > EN > hold, written as a conditional
    // chain rather than if/else: an X on a control that is actually selected
    // merges both candidates (X where they differ) instead of silently taking
    // the else branch, while an asserted higher control fully masks anything
    // on the lower ones.
    assign s_nxt = RST ? RST_BANK :
                   SE  ? s_shift  :
                   CLR ? '0       :
                   SET ? SET_BANK :
                   EN  ? s_adv    :
                         s;

    // Valid tags hold through scan and set; only reset, clear and advance move them.
    assign v_nxt = RST ? '0    :
                   SE  ? v     :
                   CLR ? '0    :
                   SET ? v     :
                   EN  ? v_adv :
                         v;

    always_ff @(negedge CLKN) begin
        s <= s_nxt;
        v <= v_nxt;
    end

    assign Q  = s[STAGES-1];
    assign QV = v[STAGES-1];
    assign SO = s[STAGES-1][WIDTH-1];

endmodule
